// File: rtl/frame_buffer_arbiter.sv
// Fixed-priority arbiter mapping client ports onto rotating frame buffers spread across
// single-port SRAM banks. Optional denied-request counters are built when FBA_STATS_EN is defined.
module frame_buffer_arbiter #(
  parameter int                   NUM_PORTS   = 4,
  parameter int                   NUM_BANKS   = 2,
  parameter int                   NUM_BUFS    = 4,
  parameter int                   ADDR_W      = 19,
  parameter int                   DATA_W      = 36,
  parameter int                   BUF_WORDS   = 76800,
  parameter int                   READ_LAT    = 2,
  parameter logic [NUM_PORTS-1:0] STREAM_MASK = 4'b1001
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        frame_flag_i,
  input  logic [NUM_PORTS-1:0]        req_i,
  input  logic [NUM_PORTS-1:0]        wr_i,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr_i,
  input  logic [NUM_PORTS*DATA_W-1:0] wdata_i,
  output logic [NUM_PORTS-1:0]        grant_o,
  output logic [NUM_PORTS-1:0]        rvalid_o,
  output logic [NUM_PORTS*DATA_W-1:0] rdata_o,
  output logic [NUM_BANKS*ADDR_W-1:0] bank_addr_o,
  output logic [NUM_BANKS*DATA_W-1:0] bank_wdata_o,
  output logic [NUM_BANKS-1:0]        bank_we_o,
  input  logic [NUM_BANKS*DATA_W-1:0] bank_rdata_i,
  output logic [NUM_PORTS*16-1:0]     stat_denied_o
);

  localparam int BASE_W = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1;
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [BASE_W-1:0]                             base_q, base_d;
  logic [NUM_PORTS-1:0][ADDR_W-1:0]              cnt_q, cnt_d;
  logic [NUM_PORTS-1:0][BANK_W-1:0]              port_bank_s;
  logic [NUM_PORTS-1:0][ADDR_W-1:0]              port_addr_s;
  logic [NUM_PORTS-1:0]                          grant_s;
  logic [NUM_BANKS-1:0]                          bank_busy_s;
  logic [NUM_BANKS-1:0][PORT_W-1:0]              bank_port_s;
  logic [NUM_BANKS-1:0][ADDR_W-1:0]              bank_addr_s;
  logic [NUM_BANKS-1:0][DATA_W-1:0]              bank_wdata_s;
  logic [NUM_BANKS-1:0]                          bank_we_s;
  logic [NUM_BANKS-1:0][READ_LAT-1:0]            pipe_vld_q, pipe_vld_d;
  logic [NUM_BANKS-1:0][READ_LAT-1:0][PORT_W-1:0] pipe_id_q, pipe_id_d;
  logic [NUM_BANKS-1:0]                          ret_vld_s;
  logic [NUM_PORTS-1:0]                          rvalid_s;
  logic [NUM_PORTS-1:0][DATA_W-1:0]              rdata_s, rdata_q;

  function automatic int buf_of(input logic [BASE_W-1:0] base, input int port);
    return (int'(base) + port) % NUM_BUFS;
  endfunction

  // Buffer placement: bank = buffer mod banks, word offset from buffer / banks
  always_comb begin
    port_bank_s = '0;
    port_addr_s = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_bank_s[p] = BANK_W'(buf_of(base_q, p) % NUM_BANKS);
      port_addr_s[p] = ADDR_W'((buf_of(base_q, p) / NUM_BANKS) * BUF_WORDS)
                     + (STREAM_MASK[p] ? cnt_q[p] : addr_i[p*ADDR_W +: ADDR_W]);
    end
  end

  // Descending scan so the lowest-numbered requester of each bank is the last writer
  always_comb begin
    bank_busy_s = '0;
    bank_port_s = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      for (int p = NUM_PORTS - 1; p >= 0; p--) begin
        bank_busy_s[k] = bank_busy_s[k]
                       | (req_i[p] && !reset && (port_bank_s[p] == BANK_W'(k)));
        bank_port_s[k] = (req_i[p] && !reset && (port_bank_s[p] == BANK_W'(k)))
                       ? PORT_W'(p) : bank_port_s[k];
      end
    end
  end

  always_comb begin
    grant_s      = '0;
    bank_addr_s  = '0;
    bank_wdata_s = '0;
    bank_we_s    = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (bank_busy_s[k]) begin
        grant_s[bank_port_s[k]] = 1'b1;
        bank_addr_s[k]          = port_addr_s[bank_port_s[k]];
        bank_wdata_s[k]         = wdata_i[int'(bank_port_s[k])*DATA_W +: DATA_W];
        bank_we_s[k]            = wr_i[bank_port_s[k]];
      end else begin
        bank_addr_s[k]  = '0;
        bank_wdata_s[k] = '0;
        bank_we_s[k]    = 1'b0;
      end
    end
  end

  // Rotation and stream counters; grants in the rotation cycle already used the old mapping
  always_comb begin
    base_d = base_q;
    cnt_d  = cnt_q;
    if (frame_flag_i) begin
      base_d = (base_q == BASE_W'(NUM_BUFS - 1)) ? '0 : base_q + BASE_W'(1);
      cnt_d  = '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        cnt_d[p] = (STREAM_MASK[p] && grant_s[p])
                 ? ((cnt_q[p] == ADDR_W'(BUF_WORDS - 1)) ? '0 : cnt_q[p] + ADDR_W'(1))
                 : cnt_q[p];
      end
    end
  end

  always_comb begin
    pipe_vld_d = '0;
    pipe_id_d  = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      pipe_vld_d[k][0] = bank_busy_s[k] & ~bank_we_s[k];
      pipe_id_d[k][0]  = bank_port_s[k];
      for (int s = 1; s < READ_LAT; s++) begin
        pipe_vld_d[k][s] = pipe_vld_q[k][s-1];
        pipe_id_d[k][s]  = pipe_id_q[k][s-1];
      end
    end
  end

  // Read return: the bank's data is routed to the issuing port in the cycle it arrives
  always_comb begin
    ret_vld_s = '0;
    rvalid_s  = '0;
    rdata_s   = reset ? '0 : rdata_q;
    for (int k = 0; k < NUM_BANKS; k++) begin
      ret_vld_s[k] = pipe_vld_q[k][READ_LAT-1] & ~reset;
      rvalid_s[pipe_id_q[k][READ_LAT-1]] = rvalid_s[pipe_id_q[k][READ_LAT-1]] | ret_vld_s[k];
      rdata_s[pipe_id_q[k][READ_LAT-1]]  = ret_vld_s[k]
                                         ? bank_rdata_i[k*DATA_W +: DATA_W]
                                         : rdata_s[pipe_id_q[k][READ_LAT-1]];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      base_q     <= '0;
      cnt_q      <= '0;
      pipe_vld_q <= '0;
      pipe_id_q  <= '0;
      rdata_q    <= '0;
    end else begin
      base_q     <= base_d;
      cnt_q      <= cnt_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_id_q  <= pipe_id_d;
      rdata_q    <= rdata_s;
    end
  end

`ifdef FBA_STATS_EN
  logic [NUM_PORTS-1:0][15:0] denied_q, denied_d;

  always_comb begin
    denied_d = denied_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      denied_d[p] = (req_i[p] && !grant_s[p] && (denied_q[p] != 16'hFFFF))
                  ? denied_q[p] + 16'd1 : denied_q[p];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      denied_q <= '0;
    end else begin
      denied_q <= denied_d;
    end
  end

  assign stat_denied_o = denied_q;
`else
  assign stat_denied_o = '0;
`endif

  assign grant_o      = grant_s;
  assign bank_addr_o  = bank_addr_s;
  assign bank_wdata_o = bank_wdata_s;
  assign bank_we_o    = bank_we_s;
  assign rvalid_o     = rvalid_s;
  assign rdata_o      = rdata_s;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Directed scenarios followed by random traffic, each cycle compared against a
// buffer-rotation reference model; the bench also plays the SRAM banks.
module tb_frame_buffer_arbiter;

  localparam int NP = 4, NB = 2, NBUF = 4, AW = 19, DW = 36, BW = 20, RL = 2;
  localparam logic [NP-1:0] SMASK = 4'b1001;

  logic clock = 1'b0;
  logic reset, frame_flag;
  logic [NP-1:0] req, wr, grant, rvalid;
  logic [NP*AW-1:0] addr;
  logic [NP*DW-1:0] wdata, rdata;
  logic [NB*AW-1:0] bank_addr;
  logic [NB*DW-1:0] bank_wdata, bank_rdata;
  logic [NB-1:0] bank_we;
  logic [NP*16-1:0] stat_denied;

  always #5 clock = ~clock;

  frame_buffer_arbiter #(
    .NUM_PORTS(NP), .NUM_BANKS(NB), .NUM_BUFS(NBUF), .ADDR_W(AW), .DATA_W(DW),
    .BUF_WORDS(BW), .READ_LAT(RL), .STREAM_MASK(SMASK)
  ) dut (
    .clock(clock), .reset(reset), .frame_flag_i(frame_flag), .req_i(req), .wr_i(wr),
    .addr_i(addr), .wdata_i(wdata), .grant_o(grant), .rvalid_o(rvalid), .rdata_o(rdata),
    .bank_addr_o(bank_addr), .bank_wdata_o(bank_wdata), .bank_we_o(bank_we),
    .bank_rdata_i(bank_rdata), .stat_denied_o(stat_denied)
  );

  int total = 0, bad = 0, cyc = 0, c_iss = 0;
  int m_base, m_cnt[NP], m_stat[NP], m_bank[NP], m_addr[NP];
  logic [DW-1:0] m_rdata[NP];
  logic [NP-1:0] e_grant;
  logic [NP*DW-1:0] e_rdata;
  int hist[NB][4];
  typedef struct { int due; int port; int bank; int addr; int issue; } rd_t;
  rd_t pend[$];

  function automatic logic [DW-1:0] data_of(input int k, input int a, input int c);
    logic [DW-1:0] v;
    v = {4'(k + 1), 14'(c), 18'(a)};
    return v ^ 36'h5A5A5A5A5;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_base = 0;
    for (int p = 0; p < NP; p++) begin
      m_cnt[p] = 0; m_stat[p] = 0; m_rdata[p] = '0;
    end
    pend.delete();
  endtask

  // Drive SRAM data, predict this cycle's outputs, compare on the falling edge
  task automatic eval();
    logic [NB*AW-1:0] e_baddr;
    logic [NB*DW-1:0] e_bwd;
    logic [NB-1:0] e_bwe;
    logic [NP-1:0] e_rv;
    logic [NP*16-1:0] e_stat;
    bit taken;
    int b;
    for (int k = 0; k < NB; k++)
      bank_rdata[k*DW +: DW] = (cyc >= RL) ? data_of(k, hist[k][(cyc-RL)%4], cyc - RL) : '0;
    e_grant = '0; e_baddr = '0; e_bwd = '0; e_bwe = '0; e_rv = '0;
    for (int p = 0; p < NP; p++) begin
      e_rdata[p*DW +: DW] = m_rdata[p];
      b = (m_base + p) % NBUF;
      m_bank[p] = b % NB;
      m_addr[p] = ((b / NB) * BW + (SMASK[p] ? m_cnt[p] : int'(addr[p*AW +: AW]))) % (1 << AW);
    end
    if (reset) begin
      e_rdata = '0;
    end else begin
      for (int k = 0; k < NB; k++) begin
        taken = 1'b0;
        for (int p = 0; p < NP; p++) begin
          if (!taken && req[p] && m_bank[p] == k) begin
            taken = 1'b1;
            e_grant[p] = 1'b1;
            e_baddr[k*AW +: AW] = AW'(m_addr[p]);
            e_bwe[k] = wr[p];
            e_bwd[k*DW +: DW] = wdata[p*DW +: DW];
          end
        end
      end
      foreach (pend[i]) begin
        if (pend[i].due == cyc) begin
          e_rv[pend[i].port] = 1'b1;
          e_rdata[pend[i].port*DW +: DW] = data_of(pend[i].bank, pend[i].addr, pend[i].issue);
        end
      end
    end
    for (int p = 0; p < NP; p++) begin
`ifdef FBA_STATS_EN
      e_stat[p*16 +: 16] = 16'(m_stat[p]);
`else
      e_stat[p*16 +: 16] = 16'h0000;
`endif
    end
    @(negedge clock);
    chk("grant", 256'(grant), 256'(e_grant));
    chk("bank_addr", 256'(bank_addr), 256'(e_baddr));
    chk("bank_we", 256'(bank_we), 256'(e_bwe));
    chk("bank_wdata", 256'(bank_wdata), 256'(e_bwd));
    chk("rvalid", 256'(rvalid), 256'(e_rv));
    chk("rdata", 256'(rdata), 256'(e_rdata));
    chk("stat_denied", 256'(stat_denied), 256'(e_stat));
    for (int k = 0; k < NB; k++) hist[k][cyc%4] = int'(bank_addr[k*AW +: AW]);
  endtask

  // Clock edge: advance the reference model with this cycle's decisions
  task automatic adv();
    @(posedge clock);
    if (reset) begin
      model_reset();
    end else begin
      for (int p = 0; p < NP; p++) begin
        m_rdata[p] = e_rdata[p*DW +: DW];
        if (req[p] && !e_grant[p] && m_stat[p] < 65535) m_stat[p]++;
        if (e_grant[p] && SMASK[p]) m_cnt[p] = (m_cnt[p] + 1) % BW;
        if (e_grant[p] && !wr[p]) pend.push_back('{cyc + RL, p, m_bank[p], m_addr[p], cyc});
      end
      for (int i = pend.size() - 1; i >= 0; i--)
        if (pend[i].due == cyc) pend.delete(i);
      if (frame_flag) begin
        m_base = (m_base + 1) % NBUF;
        for (int p = 0; p < NP; p++) m_cnt[p] = 0;
      end
    end
    cyc++;
    #1;
  endtask

  initial begin
    reset = 1'b1; frame_flag = 1'b0; req = '0; wr = '0; addr = '0; wdata = '0; bank_rdata = '0;
    for (int k = 0; k < NB; k++) for (int j = 0; j < 4; j++) hist[k][j] = 0;
    @(posedge clock); #1;
    model_reset();
    req = 4'b1111;
    eval(); adv(); eval(); adv();
    reset = 1'b0; req = '0;

    // port 0 streaming writes: bank0 addresses 0..4
    req = 4'b0001; wr = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      wdata = {4{36'($urandom)}};
      eval();
      chk("s_stream_grant", 256'(grant), 256'(4'b0001));
      chk("s_stream_addr", 256'(bank_addr[0 +: AW]), 256'(i));
      chk("s_stream_we", 256'(bank_we[0]), 256'(1'b1));
      adv();
    end

    // ports 0 and 2 collide on bank 0
    req = 4'b0101; wr = '0; addr[2*AW +: AW] = 19'd3;
    eval();
    chk("s_prio_grant", 256'(grant), 256'(4'b0001));
    adv();
    req = 4'b0100;
    eval();
    chk("s_prio_next", 256'(grant), 256'(4'b0100));
    chk("s_prio_addr", 256'(bank_addr[0 +: AW]), 256'(19'd23));
`ifdef FBA_STATS_EN
    chk("s_prio_stat", 256'(stat_denied[2*16 +: 16]), 256'(16'd1));
`endif
    adv();

    // port 1 read at 10, returns two cycles later and holds
    req = 4'b0010; addr[AW +: AW] = 19'd10; c_iss = cyc;
    eval();
    chk("s_rd_addr", 256'(bank_addr[AW +: AW]), 256'(19'd10));
    adv();
    req = '0;
    eval(); adv();
    eval();
    chk("s_rd_rvalid", 256'(rvalid[1]), 256'(1'b1));
    chk("s_rd_rdata", 256'(rdata[DW +: DW]), 256'(data_of(1, 10, c_iss)));
    adv();
    eval();
    chk("s_rd_hold_v", 256'(rvalid[1]), 256'(1'b0));
    chk("s_rd_hold_d", 256'(rdata[DW +: DW]), 256'(data_of(1, 10, c_iss)));
    adv();

    // rotation with a read in flight
    req = 4'b0010; addr[AW +: AW] = 19'd7; frame_flag = 1'b1; c_iss = cyc;
    eval(); adv();
    frame_flag = 1'b0; req = 4'b0001;
    eval();
    chk("s_rot_grant", 256'(grant), 256'(4'b0001));
    chk("s_rot_addr", 256'(bank_addr[AW +: AW]), 256'(19'd0));
    chk("s_rot_we", 256'(bank_we[1]), 256'(1'b0));
    adv();
    req = '0;
    eval();
    chk("s_rot_rvalid", 256'(rvalid[1]), 256'(1'b1));
    chk("s_rot_rdata", 256'(rdata[DW +: DW]), 256'(data_of(1, 7, c_iss)));
    adv();

    // second rotation: port 0 on buffer 2 (bank0, offset 20), run counter to wrap
    frame_flag = 1'b1;
    eval(); adv();
    frame_flag = 1'b0; req = 4'b0001; wr = 4'b0001;
    for (int i = 0; i < BW - 1; i++) begin eval(); adv(); end
    eval();
    chk("s_wrap_last", 256'(bank_addr[0 +: AW]), 256'(19'd39));
    adv();
    eval();
    chk("s_wrap_zero", 256'(bank_addr[0 +: AW]), 256'(19'd20));
    adv();

    // reset one cycle after a read grant discards it
    req = 4'b0010; wr = '0; addr[AW +: AW] = 19'd5;
    eval();
    chk("s_rst_addr", 256'(bank_addr[AW +: AW]), 256'(19'd25));
    adv();
    reset = 1'b1; req = 4'b1111;
    eval();
    chk("s_rst_grant", 256'(grant), 256'(4'b0000));
    chk("s_rst_bank", 256'({bank_addr, bank_wdata, bank_we}), 256'(0));
    chk("s_rst_rdata", 256'({rvalid, rdata}), 256'(0));
    adv();
    reset = 1'b0; req = '0;
    for (int i = 0; i < 3; i++) begin
      eval();
      chk("s_rst_norv", 256'(rvalid), 256'(4'b0000));
      adv();
    end

    // random traffic
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      frame_flag = ($urandom_range(0, 15) == 0);
      req = 4'($urandom);
      wr = 4'($urandom);
      for (int p = 0; p < NP; p++) begin
        addr[p*AW +: AW] = 19'($urandom_range(0, BW + 5));
        wdata[p*DW +: DW] = {4'($urandom), 32'($urandom)};
      end
      eval(); adv();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
